// File: rtl/inst_cache.sv
// inst_cache -- direct-mapped instruction cache, one 32-bit word per line.
//
// Sits between the core's instruction fetch port and a slower backing
// instruction memory. A hit returns the word combinationally in the same
// cycle. A miss raises stall_o, latches the line address and refills it with
// a single-word request/ack handshake.
//
// Ports:
//   clk         single clock, all state on the rising edge
//   rst         asynchronous active-low reset
//   ce_i        fetch enable from the core
//   addr_i      fetch PC (bits [1:0] ignored)
//   inst_o      fetched instruction (0 when not delivering a hit)
//   stall_o     miss stall request to the core
//   flush_i     invalidate all lines
//   mem_req_o   refill request to backing memory (held until ack)
//   mem_addr_o  refill word address, bits [1:0] = 0
//   mem_ack_i   refill data valid, single-cycle pulse
//   mem_data_i  refill word
//   hit_cnt_o   LOOKUP hit cycles    (only with ICACHE_STAT_EN, else 0)
//   miss_cnt_o  detected misses      (only with ICACHE_STAT_EN, else 0)
//
// Build option: define ICACHE_STAT_EN to build the hit/miss counters.

module inst_cache #(
    parameter int INDEX_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic [31:0] addr_i,
    output logic [31:0] inst_o,
    output logic        stall_o,
    input  logic        flush_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
);

    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = 30 - INDEX_W;

    typedef enum logic {
        LOOKUP,
        REFILL
    } state_t;

    state_t state, state_nxt;

    logic [LINES-1:0]   valid;
    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [31:0]        data_mem [LINES];
    logic               drop;
    logic [31:0]        refill_addr;

    logic [INDEX_W-1:0] idx, ridx;
    logic [TAG_W-1:0]   tag, rtag;
    logic               hit, miss, fill_done;

    assign idx  = addr_i[INDEX_W+1:2];
    assign tag  = addr_i[31:INDEX_W+2];
    assign ridx = refill_addr[INDEX_W+1:2];
    assign rtag = refill_addr[31:INDEX_W+2];

    assign mem_addr_o = refill_addr;

    logic unused_addr;
    assign unused_addr = ^addr_i[1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= LOOKUP;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        hit       = 1'b0;
        miss      = 1'b0;
        fill_done = 1'b0;
        inst_o    = '0;
        stall_o   = 1'b0;
        mem_req_o = 1'b0;
        case (state)
            LOOKUP: begin
                if (ce_i) begin
                    if (valid[idx] && tag_mem[idx] == tag) begin
                        hit    = 1'b1;
                        inst_o = data_mem[idx];
                    end else begin
                        miss      = 1'b1;
                        stall_o   = 1'b1;
                        state_nxt = REFILL;
                    end
                end
            end
            REFILL: begin
                mem_req_o = 1'b1;
                stall_o   = 1'b1;
                if (mem_ack_i) begin
                    fill_done = 1'b1;
                    state_nxt = LOOKUP;
                end
            end
            default: state_nxt = LOOKUP;
        endcase
    end

    // A flush during REFILL does not abort the outstanding request; the fill
    // still lands (tag/data written) but the drop flag keeps it invalid, so
    // the access misses again and issues a fresh request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid       <= '0;
            drop        <= 1'b0;
            refill_addr <= '0;
        end else begin
            if (miss)
                refill_addr <= {tag, idx, 2'b00};

            if (flush_i)
                valid <= '0;
            else if (fill_done && !drop)
                valid[ridx] <= 1'b1;

            if (fill_done)
                drop <= 1'b0;
            else if (flush_i && state == REFILL)
                drop <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_mem[ridx]  <= rtag;
            data_mem[ridx] <= mem_data_i;
        end
    end

`ifdef ICACHE_STAT_EN
    logic [31:0] hit_cnt, miss_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit)  hit_cnt  <= hit_cnt + 32'd1;
            if (miss) miss_cnt <= miss_cnt + 32'd1;
        end
    end

    assign hit_cnt_o  = hit_cnt;
    assign miss_cnt_o = miss_cnt;
`else
    logic unused_stat;
    assign unused_stat = hit;
    assign hit_cnt_o   = '0;
    assign miss_cnt_o  = '0;
`endif

endmodule

// File: doc/inst_cache.md
INST_CACHE -- requirements
Module: inst_cache

Interface
REQ-001 Parameter INDEX_W, default 6: index width; the cache has 2^INDEX_W lines of one 32-bit word each.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 ce_i  input  1  fetch enable from the CPU core (rom_ce_o).
REQ-005 addr_i  input  32  fetch PC from the core (rom_addr_o); bits [1:0] are ignored.
REQ-006 inst_o  output  32  instruction to the core (rom_data_i).
REQ-007 stall_o  output  1  miss stall request to the core's stall controller.
REQ-008 flush_i  input  1  invalidate all lines.
REQ-009 mem_req_o  output  1  refill request to the backing instruction memory.
REQ-010 mem_addr_o  output  32  refill word address, with bits [1:0] = 0.
REQ-011 mem_ack_i  input  1  refill data valid, single-cycle pulse.
REQ-012 mem_data_i  input  32  refill word.
REQ-013 hit_cnt_o, miss_cnt_o  output  32 each  statistics counters (see Configuration).

Function
REQ-014 Address split: index = addr_i[INDEX_W+1:2]; tag = addr_i[31:INDEX_W+2]; per line store valid, tag and data.
REQ-015 The FSM SHALL have two states, LOOKUP and REFILL; it enters LOOKUP after reset.
REQ-016 In LOOKUP, a hit is ce_i=1, valid[index]=1 and the stored tag equal to tag; on a hit, inst_o = line data combinationally in the same cycle and stall_o=0.
REQ-017 In LOOKUP, a miss (ce_i=1 and not a hit):
- stall_o=1 combinationally in the same cycle.
- The FSM SHALL move to REFILL at the next edge and latch {tag,index} into the refill address register.
REQ-018 In REFILL, the block SHALL drive mem_req_o=1, drive mem_addr_o = latched address, hold stall_o=1 and drive inst_o = 0.
REQ-019 In REFILL with mem_ack_i=1:
- At that edge the block SHALL write mem_data_i and the tag into the line, set valid, and return to LOOKUP.
- The following cycle SHALL then hit.
REQ-020 Miss penalty: with an ack N cycles after mem_req_o rises (N>=1), stall_o is high for N+1 cycles in total.
REQ-021 ce_i=0 in LOOKUP: inst_o = 0, stall_o = 0, no state change, no counter update.
REQ-022 Once REFILL is entered it SHALL complete regardless of ce_i or addr_i changes; the fill uses the latched address, never the live addr_i.
REQ-023 mem_req_o SHALL stay high continuously from REFILL entry through the ack cycle and SHALL be 0 in LOOKUP.
REQ-024 flush_i in LOOKUP SHALL clear all valid bits at the next edge; a flush in the same cycle as a lookup does not change that cycle's hit/miss result.
REQ-025 flush_i in REFILL SHALL:
- Clear all valid bits.
- Set a drop flag, so the returning fill writes data and tag but leaves valid=0.
- Return to LOOKUP, where the access misses again.
REQ-026 flush_i coincident with mem_ack_i SHALL behave as REQ-025, so the line is not validated.
REQ-027 Two addresses sharing an index SHALL evict each other (direct-mapped, no replacement state).

Reset
REQ-028 When rst is low, asynchronously:
- All valid bits and the drop flag = 0.
- State = LOOKUP.
- mem_req_o = 0, mem_addr_o = 0, counters = 0.
REQ-029 Reset asserted mid-REFILL SHALL abandon the fill; a later mem_ack_i in LOOKUP SHALL be ignored.
REQ-030 Tag and data arrays need no reset.

Configuration
REQ-031 Macro ICACHE_STAT_EN:
- Defined: hit_cnt_o increments once per LOOKUP hit cycle and miss_cnt_o once per miss detection (REQ-017, not per stall cycle); both wrap modulo 2^32.
- Undefined: the counters are not built and both outputs are constant 0.

Verification
REQ-032 After reset, ce_i=1, addr_i=0x0000_0100, ack 3 cycles after req with data 0x3401_0001:
- stall_o high for 4 cycles, mem_addr_o=0x100.
- Next cycle inst_o=0x3401_0001, stall_o=0.
REQ-033 Re-fetch 0x100 after the fill: a hit with zero stall; with ICACHE_STAT_EN, hit_cnt_o=1 and miss_cnt_o=1.
REQ-034 Fill 0x100, then fetch 0x200 (same index, INDEX_W=6): a miss, and a later 0x100 misses again.
REQ-035 flush_i pulse in REFILL before the ack of 0x104 fill:
- The ack is consumed and 0x104 misses again.
- A second mem_req_o is issued for 0x104.
REQ-036 rst low two cycles into REFILL, then a late mem_ack_i:
- mem_req_o=0 immediately and no line is validated.
- The next fetch misses.
